// File: rtl/fifo_ctrl.sv
// Sequencing controller for the register-file FIFO: pointers, fill count, per-edge decision and status flags.
// Optional macro FIFO_SIMUL_RW_EN enables simultaneous read+write when wr_en and rd_en are both high.
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic          rf_re,
  output logic [AW-1:0] rf_raddr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   data_count,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_NO_OP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WR_ERROR = 3'd3,
    ST_READ     = 3'd4,
    ST_RD_ERROR = 3'd5
  } state_e;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_ack_q, rd_ack_d;
  logic          rd_err_q, rd_err_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  always_comb begin
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    state_d  = ST_NO_OP;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    case ({wr_en, rd_en})
      2'b10: begin
        if (!full) begin
          do_wr    = 1'b1;
          state_d  = ST_WRITE;
          wr_ack_d = 1'b1;
        end else begin
          state_d  = ST_WR_ERROR;
          wr_err_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          do_rd    = 1'b1;
          state_d  = ST_READ;
          rd_ack_d = 1'b1;
        end else begin
          state_d  = ST_RD_ERROR;
          rd_err_d = 1'b1;
        end
      end
      2'b11: begin
`ifdef FIFO_SIMUL_RW_EN
        // Empty and full are exclusive since DEPTH >= 2; each direction reports its own outcome.
        if (empty) begin
          do_wr    = 1'b1;
          state_d  = ST_WRITE;
          wr_ack_d = 1'b1;
          rd_err_d = 1'b1;
        end else if (full) begin
          do_rd    = 1'b1;
          state_d  = ST_READ;
          rd_ack_d = 1'b1;
          wr_err_d = 1'b1;
        end else begin
          do_wr    = 1'b1;
          do_rd    = 1'b1;
          state_d  = ST_WRITE;
          wr_ack_d = 1'b1;
          rd_ack_d = 1'b1;
        end
`else
        state_d = ST_NO_OP;
`endif
      end
      default: state_d = ST_NO_OP;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Strobes are suppressed while reset is held so storage never captures during a flush.
  assign rf_we      = do_wr & ~reset;
  assign rf_re      = do_rd & ~reset;
  assign rf_waddr   = wr_ptr_q;
  assign rf_raddr   = rd_ptr_q;
  assign data_count = count_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: reference model pushes expected post-edge results to a scoreboard queue.
// Expectations follow FIFO_SIMUL_RW_EN when the same macro is defined for the build.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic          rf_re;
  logic [AW-1:0] rf_raddr;
  logic          full;
  logic          empty;
  logic [AW:0]   data_count;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  logic [2:0]    state;

  typedef struct {
    logic [2:0]    st;
    logic          wa;
    logic          we;
    logic          ra;
    logic          re;
    logic [AW:0]   cnt;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
  } exp_t;

  exp_t          sbQueue[$];
  int            checkCount = 0;
  int            errorCount = 0;
  int            mCount;
  logic [AW-1:0] mWp;
  logic [AW-1:0] mRp;

  fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_re(rf_re), .rf_raddr(rf_raddr),
    .full(full), .empty(empty), .data_count(data_count),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResults();
    exp_t e;
    checkOutput("sb_depth", sbQueue.size(), 1);
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput("state", state, e.st);
      checkOutput("wr_ack", wr_ack, e.wa);
      checkOutput("wr_err", wr_err, e.we);
      checkOutput("rd_ack", rd_ack, e.ra);
      checkOutput("rd_err", rd_err, e.re);
      checkOutput("data_count", data_count, e.cnt);
      checkOutput("full", full, (e.cnt == DEPTH));
      checkOutput("empty", empty, (e.cnt == 0));
      checkOutput("wr_ptr", rf_waddr, e.wp);
      checkOutput("rd_ptr", rf_raddr, e.rp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r);
    exp_t e;
    logic doW;
    logic doR;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    doW = 1'b0; doR = 1'b0;
    e.st = 3'd1; e.wa = 1'b0; e.we = 1'b0; e.ra = 1'b0; e.re = 1'b0;
    if (w && !r) begin
      if (mCount < DEPTH) begin doW = 1'b1; e.st = 3'd2; e.wa = 1'b1; end
      else begin e.st = 3'd3; e.we = 1'b1; end
    end else if (r && !w) begin
      if (mCount > 0) begin doR = 1'b1; e.st = 3'd4; e.ra = 1'b1; end
      else begin e.st = 3'd5; e.re = 1'b1; end
    end else if (r && w) begin
`ifdef FIFO_SIMUL_RW_EN
      if (mCount == 0) begin doW = 1'b1; e.st = 3'd2; e.wa = 1'b1; e.re = 1'b1; end
      else if (mCount == DEPTH) begin doR = 1'b1; e.st = 3'd4; e.ra = 1'b1; e.we = 1'b1; end
      else begin doW = 1'b1; doR = 1'b1; e.st = 3'd2; e.wa = 1'b1; e.ra = 1'b1; end
`else
      e.st = 3'd1;
`endif
    end
    #1;
    checkOutput("rf_we", rf_we, doW);
    checkOutput("rf_re", rf_re, doR);
    if (doW) checkOutput("rf_waddr", rf_waddr, mWp);
    if (doR) checkOutput("rf_raddr", rf_raddr, mRp);
    mWp    = mWp + AW'(doW);
    mRp    = mRp + AW'(doR);
    mCount = mCount + int'(doW) - int'(doR);
    e.cnt = (AW+1)'(mCount);
    e.wp  = mWp;
    e.rp  = mRp;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    checkResults();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_count"}, data_count, 0);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_waddr"}, rf_waddr, 0);
    checkOutput({tag, "_raddr"}, rf_raddr, 0);
    checkOutput({tag, "_flags"}, {wr_ack, wr_err, rd_ack, rd_err}, 0);
    checkOutput({tag, "_strobes"}, {rf_we, rf_re}, 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    mCount = 0; mWp = '0; mRp = '0;
    #12;
    checkResetState("rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("init_hold", state, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

    // Fill, overflow attempt, partial drain, refill across the wrap, full drain, underflow attempt.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1);

    // Simultaneous requests at empty, mid-fill and full.
    applyStimulus(1'b1, 1'b1);
    while (mCount < 4) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    while (mCount < DEPTH) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);

    // Asynchronous reset mid-stream with a write strobe active.
    while (mCount > 5) applyStimulus(1'b0, 1'b1);
    while (mCount < 5) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_rst_count", data_count, 5);
    #1;
    wr_en = 1'b1; rd_en = 1'b0;
    reset = 1'b1;
    #1;
    checkResetState("mid_rst");
    @(posedge clk);
    #1;
    checkResetState("held_rst");
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
    mCount = 0; mWp = '0; mRp = '0;
    #1;
    checkOutput("post_rst_state", state, 0);

    for (int i = 0; i < 80; i++) begin
      logic rw, rr;
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      applyStimulus(rw, rr);
    end

    checkOutput("sb_drained", sbQueue.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequencing controller for the 4-bit register-file FIFO: tracks read/write pointers and fill count, decides each cycle whether a write, read or error occurs, and drives write-enable/address lines into the `_dff4_r`-based storage array. Sits between the requester-facing `wr_en`/`rd_en` strobes and the storage/output-register datapath. Reports status (`full`/`empty`/`data_count`), per-operation ack/error flags and an encoded state.

## Interface
Parameters:
- `DEPTH`, 8, number of storage entries; power of two, minimum 2
- `AW`, 3, pointer width; must equal log2(`DEPTH`)

Ports:
- `clk`  in  1  clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write request, sampled at the rising edge
- `rd_en`  in  1  read request, sampled at the rising edge
- `rf_we`  out  1  storage write strobe (combinational, same cycle)
- `rf_waddr`  out  AW  storage write address (= write pointer)
- `rf_re`  out  1  output-register capture strobe (combinational, same cycle)
- `rf_raddr`  out  AW  storage read address (= read pointer)
- `full`  out  1  `data_count` == `DEPTH`
- `empty`  out  1  `data_count` == 0
- `data_count`  out  AW+1  occupied entries
- `wr_ack`  out  1  registered; previous edge performed a write
- `wr_err`  out  1  registered; previous edge rejected a write (full)
- `rd_ack`  out  1  registered; previous edge performed a read
- `rd_err`  out  1  registered; previous edge rejected a read (empty)
- `state`  out  3  registered state code

## Operation
- States: INIT=0, NO_OP=1, WRITE=2, WR_ERROR=3, READ=4, RD_ERROR=5; codes 6-7 unused and never reached.
- Decision each cycle from `wr_en`, `rd_en`, current `data_count`; the decision takes effect at the next rising edge:
  - `wr_en`=1, `rd_en`=0: not full -> WRITE (`rf_we`=1, wr_ptr+1, count+1); full -> WR_ERROR (no change).
  - `rd_en`=1, `wr_en`=0: not empty -> READ (`rf_re`=1, rd_ptr+1, count-1); empty -> RD_ERROR (no change).
  - both 0 -> NO_OP.
  - both 1 -> see Configuration.
- `rf_we`/`rf_re` are pure functions of the current decision; storage and output register capture on the same edge the pointers advance.
- Pointers wrap modulo `DEPTH` (DEPTH-1 -> 0); `data_count` saturates at neither end, since errors block overflow/underflow.
- `wr_ack`/`wr_err`/`rd_ack`/`rd_err` are one-hot with the registered state (all 0 in INIT/NO_OP); each holds for exactly one cycle per operation.
- `full`/`empty` are decoded combinationally from registered `data_count`.

## Timing
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, `data_count`=0, `state`=INIT, all ack/err=0, `empty`=1, `full`=0, `rf_we`=`rf_re`=0 while `reset`=1.
- INIT is left on the first rising edge after `reset` deasserts, by the normal decision rules.
- Latency: request sampled at edge N -> pointer/count/state/ack updated after edge N, visible in cycle N+1; `full`/`empty` reflect the new count in cycle N+1.
- Back-to-back requests are accepted every cycle; no bubbles.
- Reset asserted mid-operation discards all contents; a strobe active in that cycle has no effect.

## Configuration
- `FIFO_SIMUL_RW_EN` defined: `wr_en`=`rd_en`=1 with 0<count<DEPTH performs both (`rf_we`=`rf_re`=1, both pointers +1, count unchanged, `wr_ack`=`rd_ack`=1, `state`=WRITE). When empty -> write only (WRITE, `rd_err`=1). When full -> read only (READ, `wr_err`=1). Ack/err one-hot rule relaxed to one flag per direction.
- Not defined: `wr_en`=`rd_en`=1 -> NO_OP, no pointer/count change, all flags 0.

## Test plan
- Reset then idle: `reset` 1->0, no requests 3 cycles -> `state` INIT then NO_OP, `empty`=1, `data_count`=0, all flags 0.
- Fill: 8 consecutive writes -> `rf_waddr` 0..7, `data_count` 8, `full`=1; 9th write -> `wr_err`=1, `state`=3, count stays 8.
- Drain with wrap: 3 reads, 3 writes, then 8 reads -> `rf_waddr` wraps 7->0->2, `rf_raddr` sequence 0..7,0,1,2, final `empty`=1; extra read -> `rd_err`=1, `state`=5.
- Simultaneous request at count 4: without macro -> NO_OP, count 4; with `FIFO_SIMUL_RW_EN` -> both acks, count 4, both pointers +1.
- Reset mid-stream: assert `reset` 2 ns after an edge with count 5 -> immediately count 0, `empty`=1, pointers 0, `state` 0.
